// File: rtl/imm_pkg.sv
// imm_pkg: shared format encodings, pipeline states and XLEN check for the immediate generator
package imm_pkg;
  typedef enum logic [2:0] {
    SEL_I   = 3'd0,
    SEL_J   = 3'd1,
    SEL_S   = 3'd2,
    SEL_U   = 3'd3,
    SEL_B   = 3'd4,
    SEL_Z   = 3'd5,
    SEL_SH  = 3'd6,
    SEL_RSV = 3'd7
  } immSel_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  function automatic bit xlenLegal(input int xlen);
    return xlen == 32 || xlen == 64;
  endfunction
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32I/RV64I immediate extraction for one instruction word
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  localparam int SHW = (XLEN == 64) ? 6 : 5;
  logic unusedBits;
  assign unusedBits = ^instr[6:0];
  always_comb begin
    imm = '0;
    illegal = 1'b0;
    case (immSel_e'(sel))
      SEL_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
      SEL_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      SEL_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      SEL_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      SEL_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      SEL_Z:   imm = XLEN'(instr[19:15]);
      SEL_SH:  imm = XLEN'(instr[20+SHW-1:20]);
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator behind a registered valid/ready stage with a 2-entry skid buffer
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  state_e state, nextState;
  logic [XLEN-1:0] decImm, mImm, kImm;
  logic [TAG_W-1:0] mTag, kTag;
  logic decIll, mIll, kIll;
  logic acc, pop, loadM, loadK, moveK;
  if (!xlenLegal(XLEN)) begin : gBadXlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  imm_decode #(.XLEN(XLEN)) uDecode (
    .instr(in_instr),
    .sel(in_sel),
    .imm(decImm),
    .illegal(decIll)
  );
  // in_ready comes straight from the state register, so out_ready never reaches it combinationally
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_imm = mImm;
  assign out_tag = mTag;
  assign out_illegal = mIll;
  always_comb begin
    nextState = flush ? EMPTY :
                state == EMPTY ? (acc ? ONE : EMPTY) :
                state == ONE ? (acc && !pop ? TWO : !acc && pop ? EMPTY : ONE) :
                (pop ? ONE : TWO);
    loadM = !flush && acc && (state == EMPTY || pop);
    loadK = !flush && acc && state == ONE && !pop;
    moveK = !flush && state == TWO && pop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= nextState;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mImm <= '0;
      mTag <= '0;
      mIll <= 1'b0;
      kImm <= '0;
      kTag <= '0;
      kIll <= 1'b0;
    end else begin
      if (loadM) begin
        mImm <= decImm;
        mTag <= in_tag;
        mIll <= decIll;
      end else if (moveK) begin
        mImm <= kImm;
        mTag <= kTag;
        mIll <= kIll;
      end
      if (loadK) begin
        kImm <= decImm;
        kTag <= in_tag;
        kIll <= decIll;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed table vectors on XLEN=32 and XLEN=64 instances plus flow/flush/reset sequences
module tb_imm_gen_pipe;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0] in_sel = '0;
  logic [4:0] in_tag = '0;
  logic rdy32, rdy64, val32, val64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0] tag32, tag64;
  int nCmp = 0, nBad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag), .flush(flush), .out_valid(val32), .out_ready(out_ready),
    .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_sel(in_sel), .in_tag(in_tag), .flush(flush), .out_valid(val64), .out_ready(out_ready),
    .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkFlow(input string name, input logic v, input logic r);
    chk({name, "_valid32"}, val32, v);
    chk({name, "_valid64"}, val64, v);
    chk({name, "_ready32"}, rdy32, r);
    chk({name, "_ready64"}, rdy64, r);
  endtask

  task automatic send(input logic [4:0] tag, input logic [31:0] instr, input logic [2:0] sel);
    in_tag = tag;
    in_instr = instr;
    in_sel = sel;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [11:0] bpImm(input int t);
    return t[0] ? (12'h800 | 12'(t)) : 12'(t * 17);
  endfunction

  initial begin
    vec_t v[12];
    int sent, rcv, cnt;
    bit sawTwo, acc, pop;
    logic [11:0] b;
    logic [31:0] pat;
    v[0]  = '{32'hFFF00093, 3'd0, 5'd1,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, "I_neg1"};
    v[1]  = '{32'h123450B7, 3'd3, 5'd2,  32'h12345000, 64'h0000000012345000, 1'b0, "U_pos"};
    v[2]  = '{32'hFE000EE3, 3'd4, 5'd3,  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, "B_neg4"};
    v[3]  = '{32'h0080006F, 3'd1, 5'd4,  32'h00000008, 64'h0000000000000008, 1'b0, "J_8"};
    v[4]  = '{32'hFE20AC23, 3'd2, 5'd5,  32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, "S_neg8"};
    v[5]  = '{32'h03F00013, 3'd6, 5'd6,  32'h0000001F, 64'h000000000000003F, 1'b0, "SH_3F"};
    v[6]  = '{32'h02000013, 3'd6, 5'd7,  32'h00000000, 64'h0000000000000020, 1'b0, "SH_bit25"};
    v[7]  = '{32'h000F8073, 3'd5, 5'd8,  32'h0000001F, 64'h000000000000001F, 1'b0, "Z_1F"};
    v[8]  = '{32'h800F8073, 3'd5, 5'd9,  32'h0000001F, 64'h000000000000001F, 1'b0, "Z_nosign"};
    v[9]  = '{32'hFFFFFFFF, 3'd7, 5'd21, 32'h00000000, 64'h0000000000000000, 1'b1, "RSV"};
    v[10] = '{32'h800000B7, 3'd3, 5'd10, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, "U_neg"};
    v[11] = '{32'hFFF0006F, 3'd1, 5'd11, 32'hFFF00FFE, 64'hFFFFFFFFFFF00FFE, 1'b0, "J_neg"};

    @(posedge clk); #1;
    chkFlow("reset", 1'b0, 1'b1);
    chk("reset_imm32", imm32, 0);
    chk("reset_imm64", imm64, 0);
    chk("reset_tag", tag32, 0);
    chk("reset_ill", ill32, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    foreach (v[i]) begin
      send(v[i].tag, v[i].instr, v[i].sel);
      chkFlow(v[i].name, 1'b1, 1'b1);
      chk({v[i].name, "_imm32"}, imm32, v[i].e32);
      chk({v[i].name, "_imm64"}, imm64, v[i].e64);
      chk({v[i].name, "_tag32"}, tag32, v[i].tag);
      chk({v[i].name, "_tag64"}, tag64, v[i].tag);
      chk({v[i].name, "_ill32"}, ill32, v[i].ill);
      chk({v[i].name, "_ill64"}, ill64, v[i].ill);
    end
    @(posedge clk); #1;
    chkFlow("drain", 1'b0, 1'b1);

    // Backpressure stream: cnt models how many entries are held
    sent = 0; rcv = 0; cnt = 0; sawTwo = 0;
    pat = 32'b1011_0110_0101_1100_1101_0010_1110_0100;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      in_valid = sent < 10;
      in_tag = 5'(sent);
      in_sel = 3'd0;
      in_instr = {bpImm(sent), 20'h00093};
      out_ready = pat[cyc % 32];
      chk("bp_ready32", rdy32, cnt < 2);
      chk("bp_ready64", rdy64, cnt < 2);
      chk("bp_valid32", val32, cnt > 0);
      if (cnt == 2) sawTwo = 1;
      acc = in_valid && rdy32;
      pop = val32 && out_ready;
      if (pop) begin
        b = bpImm(rcv);
        chk("bp_tag32", tag32, 5'(rcv));
        chk("bp_tag64", tag64, 5'(rcv));
        chk("bp_imm32", imm32, {{20{b[11]}}, b});
        chk("bp_imm64", imm64, {{52{b[11]}}, b});
        rcv++;
      end
      if (acc) sent++;
      cnt = cnt + int'(acc) - int'(pop);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_received", rcv, 10);
    chk("bp_reached_two", sawTwo, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chkFlow("bp_drain", 1'b0, 1'b1);

    // Flush while full with a new request pending
    out_ready = 1'b0;
    send(5'd20, 32'hFFF00093, 3'd0);
    send(5'd21, 32'hFFF00093, 3'd0);
    chkFlow("fl_full", 1'b1, 1'b0);
    in_tag = 5'd22; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chkFlow("fl_full_after", 1'b0, 1'b1);
    // Flush in ONE with a same-cycle accept that must be discarded
    send(5'd23, 32'hFFF00093, 3'd0);
    in_tag = 5'd24; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chkFlow("fl_one_after", 1'b0, 1'b1);
    out_ready = 1'b1;
    send(5'd25, 32'h7FF00093, 3'd0);
    chkFlow("fl_next", 1'b1, 1'b1);
    chk("fl_next_tag", tag32, 25);
    chk("fl_next_imm", imm32, 32'h7FF);
    @(posedge clk); #1;
    chkFlow("fl_no_ghost", 1'b0, 1'b1);

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    send(5'd26, 32'hFFF00093, 3'd0);
    send(5'd27, 32'hFFFFFFFF, 3'd7);
    #2 rst_n = 1'b0;
    #1;
    chkFlow("arst", 1'b0, 1'b1);
    chk("arst_imm32", imm32, 0);
    chk("arst_imm64", imm64, 0);
    chk("arst_tag", tag32, 0);
    chk("arst_ill", ill32, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chkFlow("arst_idle", 1'b0, 1'b1);
    out_ready = 1'b1;
    send(5'd28, 32'h123450B7, 3'd3);
    chk("arst_recover_tag", tag32, 28);
    chk("arst_recover_imm", imm64, 64'h12345000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage. It takes a full 32-bit instruction word and an immediate-format select, then produces the sign- or zero-extended XLEN-bit immediate through a registered valid/ready stage with a 2-entry skid buffer. It adds CSR-zimm and shift-amount formats, a pass-through tag and a pipeline flush. It sits between instruction fetch/decode and the ALU operand mux, and supersedes the combinational immediate generator.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the side-band tag carried with each immediate.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept
- in_instr  in  32  full instruction word
- in_sel  in  3  format: 000 I, 001 J, 010 S, 011 U, 100 B, 101 Z (CSR zimm), 110 SH (shamt), 111 reserved
- in_tag  in  TAG_W  opaque tag, returned unchanged
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  immediate available
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  generated immediate
- out_tag  out  TAG_W  tag of out_imm
- out_illegal  out  1  in_sel was 111

## Operation
Immediate formats (i = in_instr; s = i[31] replicated to XLEN):
- I: s, i[30:20]
- S: s, i[30:25], i[11:7]
- B: s, i[7], i[30:25], i[11:8], 0
- J: s, i[19:12], i[20], i[30:21], 0
- U: s, i[30:12], 12'b0. For XLEN=64 the upper 32 bits are copies of i[31].
- Z: zero-extended i[19:15]
- SH: zero-extended i[24:20] when XLEN=32; zero-extended i[25:20] when XLEN=64
- 111: out_imm = 0 and out_illegal = 1. The entry still flows through the pipeline and is not dropped.

Generation is combinational on the input side. Results are captured into a main register M and a skid register K, each holding {imm, tag, illegal}.

States:
- EMPTY: M and K invalid.
- ONE: M valid.
- TWO: M and K valid.

Signal rules:
- in_ready = !K_valid. It is registered, so it has no combinational path from out_ready.
- out_valid = M_valid. out_* are driven from M.

Transitions (acc = in_valid & in_ready; pop = out_valid & out_ready):
- EMPTY: acc → ONE, M ← new.
- ONE: acc & !pop → TWO, K ← new. acc & pop → ONE, M ← new. !acc & pop → EMPTY.
- TWO: pop → ONE, M ← K. in_ready is 0 in TWO, so acc cannot occur.

Flush behaviour:
- flush = 1 moves the block to EMPTY at the next edge.
- Any same-cycle accept is discarded.
- A same-cycle pop is still a completed transfer downstream.

Reset:
- State EMPTY, out_valid 0, in_ready 1, out_imm 0, out_tag 0, out_illegal 0.
- Reset asserted mid-transfer discards all held entries immediately.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready is held high.
- out_* stay stable while out_valid & !out_ready. This is the standard valid/ready hold rule.
- in_instr, in_sel and in_tag are sampled only on acc.
- Entries leave in order with no duplication. K is used only when downstream stalls.

## Structure
- Shared package imm_pkg:
  - the in_sel format encodings as named constants;
  - the XLEN-legal check.
- One combinational sub-module, imm_decode: (instr, sel) → (imm, illegal), parametrised by XLEN.
- imm_gen_pipe instantiates imm_decode and holds the M/K registers and the state machine.

## Test plan
1. XLEN=32, I-format: 0xFFF00093 (addi x1,x0,-1) → out_imm 0xFFFFFFFF, one cycle after accept.
2. XLEN=32:
   - U-format 0x123450B7 → 0x12345000.
   - B-format 0xFE000EE3 → 0xFFFFFFFC.
   - J-format 0x0080006F → 0x00000008.
   - S-format 0xFE20AC23 → 0xFFFFFFF8.
3. XLEN=64:
   - I-format 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
   - SH-format with i[25:20]=0x3F → 0x3F.
   - Z-format with i[19:15]=0x1F → 0x1F.
   - Sel 111 → out_imm 0, out_illegal 1, tag preserved.
4. Backpressure: stream tags 0..9 with out_ready toggling randomly → in_ready drops only in TWO, and all 10 tags arrive in order, unduplicated, with correct immediates.
5. Flush: with 2 entries held and a new accept in the same cycle, assert flush → next cycle out_valid 0 and in_ready 1, and the flushed tags never appear.
6. Reset: assert rst_n=0 asynchronously mid-stream → out_valid, out_imm, out_tag and out_illegal go to 0 without a clock edge, and in_ready goes to 1.
